// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: single-outstanding instruction fetch controller.
// It takes a PC, issues one bus request, and holds the returned instruction (or a misalign exception) until decode accepts it.
module ifetch_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               pc_valid_i,
    output logic               pc_ready_o,
    input  logic               flush_i,
    output logic               ireq_valid_o,
    output logic [ADDR_W-1:0]  ireq_addr_o,
    input  logic               iresp_ok_i,
    input  logic [INSTR_W-1:0] iresp_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ADDR_W-1:0]  out_pc_o,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic               out_misalign_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD, HOLD} state_t;
    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 mis_q, mis_d;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (pc_valid_i && !flush_i) begin
                addr_d  = pc_i;
                mis_d   = |pc_i[1:0];
                instr_d = '0;
                state_d = |pc_i[1:0] ? HOLD : WAIT;
            end
            WAIT: if (iresp_ok_i) begin
                instr_d = iresp_data_i;
                state_d = flush_i ? IDLE : HOLD;
            end else if (flush_i) begin
                state_d = DISCARD;
            end
            DISCARD: if (iresp_ok_i) state_d = IDLE;
            default: if (flush_i || out_ready_i) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            mis_q   <= mis_d;
        end
    end
    // ready is gated by reset so it reads 0 while held in reset yet 1 on the first cycle after release
    assign pc_ready_o     = reset && state_q == IDLE;
    assign ireq_valid_o   = state_q == WAIT || state_q == DISCARD;
    assign ireq_addr_o    = ireq_valid_o ? addr_q : '0;
    assign out_valid_o    = state_q == HOLD;
    assign out_pc_o       = out_valid_o ? addr_q : '0;
    assign out_instr_o    = out_valid_o ? instr_q : '0;
    assign out_misalign_o = out_valid_o && mis_q;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scenarios plus random traffic checked against a transaction-level model.
module tb_ifetch_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic [63:0] pc_i = '0;
    logic        pc_valid_i = 0;
    logic        pc_ready_o;
    logic        flush_i = 0;
    logic        ireq_valid_o;
    logic [63:0] ireq_addr_o;
    logic        iresp_ok_i = 0;
    logic [31:0] iresp_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 0;
    logic [63:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic        out_misalign_o;

    ifetch_ctrl #(.ADDR_W(64), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i), .ireq_valid_o(ireq_valid_o), .ireq_addr_o(ireq_addr_o),
        .iresp_ok_i(iresp_ok_i), .iresp_data_i(iresp_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
        .out_misalign_o(out_misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        mis;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    bit          m_pend = 0;
    bit          m_killed = 0;
    logic [63:0] m_addr = '0;
    ent_t        m_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_killed = 0;
        m_addr = '0;
        m_q.delete();
    endtask

    task automatic check_all();
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic        e_mis;
        e_pc = '0;
        e_ins = '0;
        e_mis = 0;
        if (m_q.size() != 0) begin
            e_pc = m_q[0].pc;
            e_ins = m_q[0].ins;
            e_mis = m_q[0].mis;
        end
        check("pc_ready", pc_ready_o, 64'(!m_pend && m_q.size() == 0));
        check("ireq_valid", ireq_valid_o, 64'(m_pend));
        check("ireq_addr", ireq_addr_o, m_pend ? m_addr : 64'd0);
        check("out_valid", out_valid_o, 64'(m_q.size() != 0));
        check("out_pc", out_pc_o, e_pc);
        check("out_instr", out_instr_o, 64'(e_ins));
        check("out_misalign", out_misalign_o, 64'(e_mis));
        check("out_ireq_excl", out_valid_o & ireq_valid_o, 64'd0);
    endtask

    // One cycle of the transaction model: a held entry, else an outstanding bus fetch, else an idle slot.
    task automatic model_step();
        ent_t e;
        if (m_q.size() != 0) begin
            if (flush_i || out_ready_i) void'(m_q.pop_front());
        end else if (m_pend) begin
            if (iresp_ok_i) begin
                if (!m_killed && !flush_i) begin
                    e.pc = m_addr; e.ins = iresp_data_i; e.mis = 0;
                    m_q.push_back(e);
                end
                m_pend = 0;
            end else if (flush_i) begin
                m_killed = 1;
            end
        end else if (pc_valid_i && !flush_i) begin
            if (pc_i[1:0] != 2'b00) begin
                e.pc = pc_i; e.ins = '0; e.mis = 1;
                m_q.push_back(e);
            end else begin
                m_pend = 1; m_addr = pc_i; m_killed = 0;
            end
        end
    endtask

    task automatic cyc(input logic pv, input logic [63:0] pc, input logic fl,
                       input logic ok, input logic [31:0] d, input logic ordy);
        check_all();
        pc_valid_i = pv; pc_i = pc; flush_i = fl;
        iresp_ok_i = ok; iresp_data_i = d; out_ready_i = ordy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_pc_ready", pc_ready_o, 64'd0);
        check("rst_ireq", ireq_valid_o, 64'd0);
        check("rst_out_valid", out_valid_o, 64'd0);
        #10 reset = 1;
        #1 check("first_ready", pc_ready_o, 64'd1);
        @(posedge clk); #1;
        model_reset();
        // basic fetch: accept at 0, ok at 3, present at 4
        cyc(1, 64'h8000_0000, 0, 0, 0, 0);
        check("c1_ireq_addr", ireq_addr_o, 64'h8000_0000);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("c3_ireq", ireq_valid_o, 64'd1);
        cyc(0, 0, 0, 1, 32'h0000_0013, 0);
        check("c4_instr", out_instr_o, 64'h13);
        check("c4_valid", out_valid_o, 64'd1);
        // decode stalls for five cycles
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
        check("stall_pc", out_pc_o, 64'h8000_0000);
        cyc(0, 0, 0, 0, 0, 1);
        // flush while waiting, response arrives later and is discarded
        cyc(1, 64'h0000_1000, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("discard_ireq", ireq_valid_o, 64'd1);
        cyc(0, 0, 0, 1, 32'hdead_beef, 1);
        check("discard_ready", pc_ready_o, 64'd1);
        check("discard_noout", out_valid_o, 64'd0);
        // flush and response in the same cycle
        cyc(1, 64'h0000_2000, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 32'h1234_5678, 1);
        check("same_ready", pc_ready_o, 64'd1);
        // misaligned pc, then flush out of the hold slot
        cyc(1, 64'h8000_0002, 0, 0, 0, 0);
        check("mis_flag", out_misalign_o, 64'd1);
        check("mis_pc", out_pc_o, 64'h8000_0002);
        cyc(0, 0, 1, 0, 0, 0);
        // flush in idle blocks acceptance
        cyc(1, 64'h0000_3000, 1, 0, 0, 0);
        check("idle_flush", ireq_valid_o, 64'd0);
        // asynchronous reset in the middle of a wait
        cyc(1, 64'h0000_4000, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #2 reset = 0;
        #1;
        check("ar_ireq", ireq_valid_o, 64'd0);
        check("ar_addr", ireq_addr_o, 64'd0);
        check("ar_ready", pc_ready_o, 64'd0);
        check("ar_out", out_valid_o, 64'd0);
        model_reset();
        @(posedge clk); #1;
        @(negedge clk) reset = 1;
        #1 check("ar_first_ready", pc_ready_o, 64'd1);
        @(posedge clk); #1;
        cyc(0, 0, 0, 1, 32'hffff_ffff, 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("ar_late_ok", out_valid_o, 64'd0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] pc;
            pc = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            cyc(1'($urandom_range(0, 1)), pc, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 3, $urandom, 1'($urandom_range(0, 1)));
        end
        check_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 64, meaning fetch address width.
REQ-002 The module SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset; state clears when reset=0, independent of clk.
REQ-005 pc_i  in  ADDR_W  fetch address from the PC register.
REQ-006 pc_valid_i  in  1  pc_i is valid this cycle.
REQ-007 pc_ready_o  out  1  controller accepts pc_i; transfer when pc_valid_i & pc_ready_o.
REQ-008 flush_i  in  1  redirect; kill any in-flight or held fetch.
REQ-009 ireq_valid_o  out  1  instruction-bus request valid.
REQ-010 ireq_addr_o  out  ADDR_W  instruction-bus request address.
REQ-011 iresp_ok_i  in  1  bus data_ok; iresp_data_i valid this cycle.
REQ-012 iresp_data_i  in  INSTR_W  returned instruction.
REQ-013 out_valid_o  out  1  fetched instruction valid to decode.
REQ-014 out_ready_i  in  1  decode accepts; transfer when out_valid_o & out_ready_i.
REQ-015 out_pc_o  out  ADDR_W  address of the presented instruction.
REQ-016 out_instr_o  out  INSTR_W  presented instruction; 0 when misaligned.
REQ-017 out_misalign_o  out  1  presented entry is a misaligned-fetch exception.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, DISCARD, HOLD; pc_ready_o=1 only in IDLE.
REQ-019 IDLE, accepted pc with flush_i=0 and pc_i[1:0]==0: latch address, go WAIT; ireq_valid_o=1 from next cycle.
REQ-020 IDLE, accepted pc with pc_i[1:0]!=0 and flush_i=0: no bus request; go HOLD with out_misalign_o=1, out_instr_o=0, out_pc_o=pc_i.
REQ-021 IDLE with flush_i=1: no pc accepted (pc_ready_o still 1 but transfer ignored); stay IDLE.
REQ-022 WAIT: ireq_valid_o=1, ireq_addr_o constant until iresp_ok_i; request never withdrawn before iresp_ok_i.
REQ-023 WAIT, iresp_ok_i=1, flush_i=0: capture iresp_data_i, go HOLD; out_valid_o=1 the next cycle.
REQ-024 WAIT, flush_i=1, iresp_ok_i=0: go DISCARD.
REQ-025 WAIT, flush_i=1 and iresp_ok_i=1 same cycle: drop data, go IDLE.
REQ-026 DISCARD: ireq_valid_o=1 with same address; out_valid_o=0; on iresp_ok_i drop data, go IDLE; further flush_i ignored.
REQ-027 HOLD: out_valid_o=1, out_pc_o/out_instr_o/out_misalign_o stable until handshake; on out_ready_i=1 go IDLE.
REQ-028 HOLD, flush_i=1: go IDLE regardless of out_ready_i; flush priority, the transfer is void.
REQ-029 Latency SHALL be: pc accepted cycle N, ireq_valid_o at N+1, iresp_ok_i at cycle M>=N+1, out_valid_o at M+1.
REQ-030 There SHALL be no bypass: at most one fetch outstanding; minimum 3 cycles per instruction.
REQ-031 out_valid_o and ireq_valid_o SHALL never both be 1; outside HOLD, out_* SHALL be 0.

Reset
REQ-032 While reset=0: state IDLE; pc_ready_o, ireq_valid_o, out_valid_o, out_misalign_o = 0; all address/data outputs 0.
REQ-033 Reset asserted in WAIT/DISCARD SHALL abandon the request; a subsequent iresp_ok_i in IDLE SHALL be ignored.
REQ-034 After reset deasserts, pc_ready_o=1 on the first cycle.

Verification
REQ-035 pc_i=0x8000_0000 accepted cycle 0, iresp_ok_i cycle 3 with 0x00000013 -> ireq cycles 1-3 addr 0x8000_0000; out_valid_o cycle 4, out_instr_o=0x00000013.
REQ-036 Out stalled: out_ready_i=0 for 5 cycles in HOLD -> outputs stable, pc_ready_o=0, ireq_valid_o=0 throughout.
REQ-037 flush_i cycle 2 during WAIT, ok cycle 4 -> ireq held to cycle 4, out_valid_o never 1, pc_ready_o=1 cycle 5.
REQ-038 flush_i and iresp_ok_i same cycle -> data dropped, IDLE next cycle, no out_valid_o.
REQ-039 pc_i=0x8000_0002 -> no ireq_valid_o; out_valid_o=1, out_misalign_o=1, out_pc_o=0x8000_0002 next cycle.
REQ-040 reset=0 mid-WAIT asynchronously -> all outputs 0 immediately; later iresp_ok_i produces no out_valid_o.
